tilt_move_gen: RTL and testbench
================================

# tilt_move_gen

Converts raw accelerometer tilt samples into the one-hot `movement` direction and the step-rate tick consumed by the ball stage. Sits directly upstream of the ball logic: the accelerometer SPI reader feeds it signed X/Y samples, and its outputs drive the ball's `movement` and `update` inputs. It averages samples, applies a deadzone, picks the dominant axis and emits steps at one of two rates, set by tilt magnitude.

## Interface
- `AVG_LOG2`, 3: samples averaged per decision = 2^AVG_LOG2 (range 0..4).
- `DEADZONE`, 100: magnitude (unsigned, in counts) below which there is no movement.
- `FAST_THRESH`, 400: magnitude at or above which the fast rate is used.
- `SLOW_PERIOD`, 1666666: clocks per step at the slow rate (60 Hz at 100 MHz).
- `FAST_PERIOD`, 416666: clocks per step at the fast rate (240 Hz). Must be ≥2 and ≤ SLOW_PERIOD.
- `CNTR_WIDTH`, 32: width of the period counter.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `accel_x` in 12: signed two's-complement X tilt sample.
- `accel_y` in 12: signed two's-complement Y tilt sample.
- `sample_valid` in 1: one-cycle strobe; `accel_x` and `accel_y` are valid in that cycle.
- `hold` in 1: freeze. While high, `step_tick` is suppressed and the period counter holds. Used on game over.
- `movement` out 4: one-hot direction. UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000, none=0000.
- `fast` out 1: high when the current decision uses FAST_PERIOD.
- `step_tick` out 1: one-cycle pulse per ball step.
- `avg_x` out 12: last averaged X, for debug and LEDs.
- `avg_y` out 12: last averaged Y, for debug and LEDs.

## Operation
- **Accumulate.** On each `sample_valid`, add the sign-extended samples to accumulators of 12+AVG_LOG2 bits and increment `samp_cnt` (AVG_LOG2 bits).
  - On the 2^AVG_LOG2-th sample, the accumulators and count clear in that same cycle.
  - The next-cycle `avg_x`/`avg_y` = sum >>> AVG_LOG2 (arithmetic shift, truncation toward −∞).
  - Samples arriving in the cycle of the clear start the next window.
- **Decide.** One cycle after the average is registered:
  - |avg| is computed in 12-bit unsigned, so −2048 gives 2048 with no overflow.
  - mag = max(|x|, |y|). X wins a tie.
  - If mag < DEADZONE, then `movement`=0000 and `fast`=0.
  - Otherwise, for the X axis: x>0 → RIGHT, x<0 → LEFT. For the Y axis: y>0 → DOWN, y<0 → UP.
  - `fast` = (mag ≥ FAST_THRESH).
  - `movement` and `fast` change only at decision cycles. They are held in between.
- **Rate.** The period counter `pcnt` runs while `movement`≠0 and `hold`=0.
  - When pcnt == period−1, `step_tick`=1 for one cycle and pcnt wraps to 0.
  - Here period is FAST_PERIOD if `fast`, else SLOW_PERIOD.
- **Direction change**, including from 0000: pcnt clears to 0 in the decision cycle. The first tick therefore comes a full period later, with no stale tick.
- **Speed change with the same direction:** pcnt is not cleared. If pcnt ≥ new period−1, the tick fires next cycle and pcnt wraps. The compare is ≥, not ==.
- **Movement to 0000:** pcnt clears and no ticks are emitted.
- **`hold` high:** pcnt holds its value and no tick is emitted. Averaging and decisions continue. On release, counting resumes from the held value.
- **Reset:**
  - Outputs: `movement`=0000, `fast`=0, `step_tick`=0, `avg_x`=0, `avg_y`=0.
  - Internal: accumulators, `samp_cnt` and pcnt are 0.
  - A partial averaging window is discarded.

## Timing
- Latency from the last sample of a window (cycle N) to outputs:
  - `avg_*` registered at N+1.
  - `movement`/`fast` valid at N+2.
- The first `step_tick` after a new non-zero direction comes at N+2+period.
- Ticks are spaced exactly `period` clocks apart while direction, speed and `hold` are steady.
- `step_tick` is never asserted in the same cycle as `reset`, or while `hold`=1 or `movement`=0.
- `sample_valid` may be asserted on consecutive cycles. No back-pressure: every strobe is consumed.
- Reset takes priority over all other inputs in the same cycle.

## Test plan
Bench parameters: AVG_LOG2=2, SLOW_PERIOD=10, FAST_PERIOD=4, DEADZONE=100, FAST_THRESH=400.

1. **Slow RIGHT.** Four samples x=200, y=50, last at cycle N.
   - `avg_x`=200 at N+1.
   - `movement`=1000 and `fast`=0 at N+2.
   - `step_tick` at N+12, N+22, N+32.
2. **Deadzone and negative averaging.** Samples x={−99,−99,−99,−101}, y=0.
   - `avg_x`=−100 (sum −398 >>> 2 = −100 by floor), so `movement`=0100.
   - Repeat with all four samples at −99: `movement`=0000 and no ticks.
3. **Tie, fast and extreme value.**
   - x=−2048, y=2047 → `movement`=0100, `fast`=1, tick every 4 clocks.
   - x=500, y=−500 → `movement`=1000 (X wins the tie).
4. **Speed change mid-period.** Steady RIGHT slow with pcnt=7, then a decision with mag=450 in the same direction. A tick fires the next cycle, followed by ticks every 4 clocks.
5. **Direction change.** While ticking RIGHT, switch to y=−300 (UP). At the decision cycle, `movement`=0001 and pcnt=0. The next tick comes exactly 10 clocks later.
6. **Hold and reset.**
   - Assert `hold` for 25 clocks mid-period: no ticks. After release, the tick comes at 10 − (pre-hold count) clocks.
   - Assert `reset` after two of four samples: all outputs 0. The next four samples form a fresh average.

Source files
------------

// File: rtl/tilt_move_gen.sv
// tilt_move_gen: turns signed accelerometer X/Y samples into a one-hot ball
// direction and a step-rate tick for the ball stage.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   accel_x/y     signed 12-bit tilt samples, valid when sample_valid is high
//   sample_valid  one-cycle sample strobe (may be asserted back to back)
//   hold          freezes the step counter and suppresses step_tick
//   movement      one-hot direction: UP=0001 DOWN=0010 LEFT=0100 RIGHT=1000
//   fast          current decision uses FAST_PERIOD
//   step_tick     one-cycle pulse per ball step
//   avg_x/y       last averaged sample pair
module tilt_move_gen #(
    parameter int unsigned AVG_LOG2    = 3,
    parameter int unsigned DEADZONE    = 100,
    parameter int unsigned FAST_THRESH = 400,
    parameter int unsigned SLOW_PERIOD = 1666666,
    parameter int unsigned FAST_PERIOD = 416666,
    parameter int unsigned CNTR_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] accel_x,
    input  logic [11:0] accel_y,
    input  logic        sample_valid,
    input  logic        hold,
    output logic [3:0]  movement,
    output logic        fast,
    output logic        step_tick,
    output logic [11:0] avg_x,
    output logic [11:0] avg_y
);

    localparam int unsigned SAMP_W = 12;
    localparam int unsigned ACC_W  = SAMP_W + AVG_LOG2;
    // Keep the sample counter at least one bit wide when no averaging is used
    localparam int unsigned CNT_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'((1 << AVG_LOG2) - 1);

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam logic [CNTR_WIDTH-1:0] FAST_M1 = CNTR_WIDTH'(FAST_PERIOD - 1);
    localparam logic [CNTR_WIDTH-1:0] SLOW_M1 = CNTR_WIDTH'(SLOW_PERIOD - 1);

    // Registered state
    logic signed [ACC_W-1:0]  acc_x_q, acc_y_q;
    logic [CNT_W-1:0]         samp_cnt_q;
    logic                     avg_valid_q;
    logic [CNTR_WIDTH-1:0]    pcnt_q;

    // Next-state values
    logic signed [ACC_W-1:0]  acc_x_d, acc_y_d;
    logic signed [ACC_W-1:0]  sum_x, sum_y;
    logic [CNT_W-1:0]         samp_cnt_d;
    logic                     win_done;
    logic [11:0]              avg_x_d, avg_y_d;
    logic [3:0]               movement_d;
    logic                     fast_d;
    logic                     tick_d;
    logic [CNTR_WIDTH-1:0]    pcnt_d;

    // Decision terms
    logic [11:0]              abs_x, abs_y, mag;
    logic                     x_wins, in_dead, dir_change;
    logic [3:0]               dir_dec;
    logic                     fast_dec;
    logic [CNTR_WIDTH-1:0]    period_m1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            samp_cnt_q  <= '0;
            avg_valid_q <= 1'b0;
            avg_x       <= '0;
            avg_y       <= '0;
            movement    <= DIR_NONE;
            fast        <= 1'b0;
            pcnt_q      <= '0;
            step_tick   <= 1'b0;
        end else begin
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            samp_cnt_q  <= samp_cnt_d;
            avg_valid_q <= win_done;
            avg_x       <= avg_x_d;
            avg_y       <= avg_y_d;
            movement    <= movement_d;
            fast        <= fast_d;
            pcnt_q      <= pcnt_d;
            step_tick   <= tick_d;
        end
    end

    // Accumulate samples; the window's last sample clears the sums and loads the average
    always_comb begin
        sum_x      = acc_x_q + ACC_W'(signed'(accel_x));
        sum_y      = acc_y_q + ACC_W'(signed'(accel_y));
        win_done   = sample_valid && (samp_cnt_q == LAST_SAMP);
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        samp_cnt_d = samp_cnt_q;
        avg_x_d    = avg_x;
        avg_y_d    = avg_y;
        if (sample_valid) begin
            if (win_done) begin
                acc_x_d    = '0;
                acc_y_d    = '0;
                samp_cnt_d = '0;
                avg_x_d    = 12'(sum_x >>> AVG_LOG2);
                avg_y_d    = 12'(sum_y >>> AVG_LOG2);
            end else begin
                acc_x_d    = sum_x;
                acc_y_d    = sum_y;
                samp_cnt_d = samp_cnt_q + CNT_W'(1);
            end
        end
    end

    // Direction decision from the registered average; 12-bit unsigned magnitude
    // keeps -2048 as 2048
    always_comb begin
        abs_x    = avg_x[11] ? 12'(~avg_x + 12'd1) : avg_x;
        abs_y    = avg_y[11] ? 12'(~avg_y + 12'd1) : avg_y;
        x_wins   = (abs_x >= abs_y);
        mag      = x_wins ? abs_x : abs_y;
        in_dead  = (32'(mag) < DEADZONE);
        dir_dec  = DIR_NONE;
        if (!in_dead) begin
            if (x_wins) begin
                if (avg_x[11])          dir_dec = DIR_LEFT;
                else if (avg_x != 12'd0) dir_dec = DIR_RIGHT;
            end else begin
                if (avg_y[11])          dir_dec = DIR_UP;
                else if (avg_y != 12'd0) dir_dec = DIR_DOWN;
            end
        end
        fast_dec   = !in_dead && (32'(mag) >= FAST_THRESH);
        movement_d = avg_valid_q ? dir_dec  : movement;
        fast_d     = avg_valid_q ? fast_dec : fast;
        dir_change = avg_valid_q && (dir_dec != movement);
    end

    // Step-rate counter; >= compare lets a speed-up past the new period tick at once
    always_comb begin
        period_m1 = fast ? FAST_M1 : SLOW_M1;
        pcnt_d    = pcnt_q;
        tick_d    = 1'b0;
        if (dir_change || (movement == DIR_NONE)) begin
            pcnt_d = '0;
        end else if (!hold) begin
            if (pcnt_q >= period_m1) begin
                tick_d = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + CNTR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tilt_move_gen.sv
// Directed testbench for tilt_move_gen with small periods (slow 10, fast 4)
// and 4-sample averaging.
module tb_tilt_move_gen;

    logic        clk;
    logic        reset;
    logic [11:0] accel_x;
    logic [11:0] accel_y;
    logic        sample_valid;
    logic        hold;
    logic [3:0]  movement;
    logic        fast;
    logic        step_tick;
    logic [11:0] avg_x;
    logic [11:0] avg_y;

    int n_tests = 0;
    int n_fail  = 0;

    tilt_move_gen #(
        .AVG_LOG2   (2),
        .DEADZONE   (100),
        .FAST_THRESH(400),
        .SLOW_PERIOD(10),
        .FAST_PERIOD(4),
        .CNTR_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .sample_valid(sample_valid),
        .hold        (hold),
        .movement    (movement),
        .fast        (fast),
        .step_tick   (step_tick),
        .avg_x       (avg_x),
        .avg_y       (avg_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One sample strobe in the current cycle; returns in the following cycle
    task automatic send1(input int x, input int y);
        sample_valid = 1'b1;
        accel_x      = 12'(x);
        accel_y      = 12'(y);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send4(input int x, input int y);
        for (int i = 0; i < 4; i++) send1(x, y);
    endtask

    // Advance k cycles; step_tick must be low except in the k-th
    task automatic wait_tick(input string tag, input int k);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            check(tag, 32'(step_tick), 32'(i == k));
        end
    endtask

    task automatic no_tick(input string tag, input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check(tag, 32'(step_tick), 32'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        hold         = 1'b0;
        accel_x      = '0;
        accel_y      = '0;
        repeat (3) step();
        check("rst_mov",  32'(movement),  32'h0);
        check("rst_fast", 32'(fast),      32'h0);
        check("rst_tick", 32'(step_tick), 32'h0);
        check("rst_avgx", 32'(avg_x),     32'h0);
        check("rst_avgy", 32'(avg_y),     32'h0);
        reset = 1'b0;
        step();

        // Slow RIGHT
        send4(200, 50);
        check("t1_avgx", 32'(avg_x), 32'd200);
        check("t1_avgy", 32'(avg_y), 32'd50);
        check("t1_mov_lat", 32'(movement), 32'h0);
        step();
        check("t1_mov",  32'(movement), 32'h8);
        check("t1_fast", 32'(fast),     32'h0);
        wait_tick("t1_tick1", 10);
        wait_tick("t1_tick2", 10);
        wait_tick("t1_tick3", 10);

        // Deadzone boundary with floor averaging of negatives
        send1(-99, 0);
        send1(-99, 0);
        send1(-99, 0);
        send1(-101, 0);
        check("t2_avgx_m100", 32'(avg_x), 32'h0000_0F9C);
        step();
        check("t2_mov_left", 32'(movement), 32'h4);
        check("t2_fast",     32'(fast),     32'h0);
        send4(-99, 0);
        check("t2_avgx_m99", 32'(avg_x), 32'h0000_0F9D);
        step();
        check("t2_mov_none", 32'(movement), 32'h0);
        no_tick("t2_no_tick", 15);

        // Extreme value and tie-break
        send4(-2048, 2047);
        check("t3_avgx", 32'(avg_x), 32'h0000_0800);
        check("t3_avgy", 32'(avg_y), 32'h0000_07FF);
        step();
        check("t3_mov_left", 32'(movement),  32'h4);
        check("t3_fast",     32'(fast),      32'h1);
        check("t3_no_stale", 32'(step_tick), 32'h0);
        wait_tick("t3_tick1", 4);
        wait_tick("t3_tick2", 4);
        send4(500, -500);
        step();
        check("t3_tie_right", 32'(movement),  32'h8);
        check("t3_tie_fast",  32'(fast),      32'h1);
        check("t3_tie_stale", 32'(step_tick), 32'h0);
        wait_tick("t3_tie_tick", 4);

        // Speed change mid-period: slow RIGHT reaches pcnt=7 at the fast decision
        send4(0, 0);
        step();
        check("t4_mov_none", 32'(movement), 32'h0);
        send4(200, 0);
        check("t4_avgx", 32'(avg_x), 32'd200);
        step();
        check("t4_mov_slow",  32'(movement), 32'h8);
        check("t4_fast_slow", 32'(fast),     32'h0);
        repeat (3) step();
        send4(450, 0);
        check("t4_mov_pre",  32'(movement),  32'h8);
        check("t4_fast_pre", 32'(fast),      32'h0);
        check("t4_tick_pre", 32'(step_tick), 32'h0);
        step();
        check("t4_fast_new", 32'(fast),      32'h1);
        check("t4_mov_same", 32'(movement),  32'h8);
        check("t4_tick_dec", 32'(step_tick), 32'h0);
        wait_tick("t4_tick_now", 1);
        wait_tick("t4_tick_f1", 4);
        wait_tick("t4_tick_f2", 4);

        // Direction change to UP clears the counter
        send4(0, -300);
        step();
        check("t5_mov_up",   32'(movement),  32'h1);
        check("t5_fast",     32'(fast),      32'h0);
        check("t5_no_stale", 32'(step_tick), 32'h0);
        wait_tick("t5_tick", 10);

        // Hold with pcnt=3, then resume from the held count
        repeat (3) step();
        hold = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            check("t6_hold_tick", 32'(step_tick), 32'h0);
        end
        check("t6_hold_mov", 32'(movement), 32'h1);
        hold = 1'b0;
        wait_tick("t6_resume", 7);

        // Reset mid-window discards the partial sums
        send1(1000, 0);
        send1(1000, 0);
        reset = 1'b1;
        step();
        check("t6_rst_mov",  32'(movement),  32'h0);
        check("t6_rst_fast", 32'(fast),      32'h0);
        check("t6_rst_tick", 32'(step_tick), 32'h0);
        check("t6_rst_avgx", 32'(avg_x),     32'h0);
        check("t6_rst_avgy", 32'(avg_y),     32'h0);
        reset = 1'b0;
        send4(-300, 0);
        check("t6_fresh_avgx", 32'(avg_x), 32'h0000_0ED4);
        step();
        check("t6_fresh_mov",  32'(movement), 32'h4);
        check("t6_fresh_fast", 32'(fast),     32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
